// File: rtl/vedic_mul_arbiter_if.sv
// Request/response bundle for the shared vedic multiplier arbiter.
// The arbiter sits on the slave side, requesters and sink on the master side.
interface vedic_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, busy
    );
endinterface

// File: rtl/vedic_mul_arbiter.sv
// Round-robin arbiter sharing one 2-stage vedic 16x16 multiplier,
// with a tag pipeline and a credit-protected response FIFO.
module vedic_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    vedic_mul_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    nxt_ptr;
    logic               found;
    logic [NUM_REQ-1:0] grant;
    logic               hs;
    logic               can_issue;
    logic [CW:0]        outstanding;

    logic [15:0] mul_a, mul_b;
    logic [15:0] a_q, b_q;
    logic [15:0] p_ll, p_lh, p_hl, p_hh;
    logic [31:0] prod, prod_q;

    logic            tag1_v, tag2_v;
    logic [ID_W-1:0] tag1_id, tag2_id;

    logic [ID_W-1:0] mem_id  [FIFO_DEPTH];
    logic [31:0]     mem_res [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;

    assign outstanding = {1'b0, count} + (CW+1)'(tag1_v) + (CW+1)'(tag2_v);
    assign can_issue   = outstanding < (CW+1)'(FIFO_DEPTH);

    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
        if (found && can_issue)
            grant[win] = 1'b1;
    end

    assign hs            = |grant;
    assign bus.req_ready = grant;
    assign nxt_ptr = (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mul_a = bus.req_a[16*i +: 16];
                mul_b = bus.req_b[16*i +: 16];
            end
        end
    end

    // Vedic split: four 8x8 crosswise products summed with shifts
    assign p_ll = {8'b0, a_q[7:0]}  * {8'b0, b_q[7:0]};
    assign p_lh = {8'b0, a_q[7:0]}  * {8'b0, b_q[15:8]};
    assign p_hl = {8'b0, a_q[15:8]} * {8'b0, b_q[7:0]};
    assign p_hh = {8'b0, a_q[15:8]} * {8'b0, b_q[15:8]};
    assign prod = {p_hh, p_ll}
                + {8'b0, p_lh, 8'b0}
                + {8'b0, p_hl, 8'b0};

    always_ff @(posedge clk) begin
        a_q    <= mul_a;
        b_q    <= mul_b;
        prod_q <= prod;
    end

    assign push = tag2_v;
    assign pop  = bus.rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            tag1_v  <= 1'b0;
            tag1_id <= '0;
            tag2_v  <= 1'b0;
            tag2_id <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            if (hs)
                rr_ptr <= nxt_ptr;
            tag1_v  <= hs;
            tag1_id <= win;
            tag2_v  <= tag1_v;
            tag2_id <= tag1_id;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]  <= tag2_id;
            mem_res[wr_ptr] <= prod_q;
        end
    end

    assign bus.rsp_valid  = (count != '0);
    assign bus.rsp_id     = bus.rsp_valid ? mem_id[rd_ptr]  : '0;
    assign bus.rsp_result = bus.rsp_valid ? mem_res[rd_ptr] : '0;
    assign bus.busy       = tag1_v | tag2_v | (count != '0);
endmodule

// File: doc/vedic_mul_arbiter.md
Name: vedic_mul_arbiter

Overview:
- Shares one vedic_16x16 multiplier between NUM_REQ requesters, each with its own valid/ready request port.
- Round-robin arbitration issues at most one multiply per cycle.
- A tag pipeline tracks each operation through the multiplier's fixed 2-stage register path.
- Results go into a credit-protected output FIFO and leave through one valid/ready response port tagged with the requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must equal clog2(NUM_REQ).
- FIFO_DEPTH, 4, response FIFO entries and maximum outstanding operations (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  16*NUM_REQ  operand A; requester i uses bits [16i+15:16i].
- req_b  in  16*NUM_REQ  operand B, same packing as req_a.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  downstream accepts response.
- rsp_id  out  ID_W  index of the requester that owns rsp_result.
- rsp_result  out  32  unsigned product a*b.
- busy  out  1  any operation in flight or buffered.

Behaviour:
- Reset (rst_n low at a clk edge):
  - rr_ptr is set to 0.
  - Both tag stages are cleared.
  - FIFO read pointer, write pointer and count are cleared.
  - Outputs after reset: rsp_valid=0, busy=0, req_ready=0, rsp_id=0, rsp_result=0.
  - Reset mid-operation discards all in-flight and buffered results. Stale data inside the multiplier is never pushed because the tag valids are cleared.
- Credit:
  - outstanding = tag1_v + tag2_v + fifo_count.
  - Issue is allowed only when outstanding < FIFO_DEPTH.
  - A same-cycle pop returns no credit; the credit becomes available the next cycle.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit wins, provided issue is allowed.
  - req_ready = grant. It depends combinationally on req_valid; requesters must not make valid depend on ready.
  - Handshake occurs when req_valid[i] and req_ready[i] are both high.
  - On a handshake: rr_ptr <= (winner+1) mod NUM_REQ. Otherwise rr_ptr holds.
- Datapath:
  - The winner's operands drive the multiplier a/b in the handshake cycle. With no grant, a/b are driven with 0.
  - The multiplier registers its inputs at edge t and its result at edge t+1.
- Tag pipeline:
  - tag1 {v,id} is loaded at edge t with the handshake.
  - tag2 <= tag1 at edge t+1, so tag2 is aligned with the multiplier result register.
  - While tag2_v is set, the {id, result} pair is written to the FIFO at edge t+2.
  - Accept-to-rsp_valid latency is 3 cycles when the FIFO is empty. Back-to-back issue gives one response per cycle.
- FIFO:
  - Registered, FIFO_DEPTH entries.
  - rsp_valid = (count != 0). rsp_id and rsp_result come from the head entry and are held stable while rsp_valid=1 and rsp_ready=0.
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Push when full is unreachable by the credit rule; the bench asserts this.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering: responses leave in issue order. Two operations from the same requester are never reordered.
- Arithmetic: unsigned 16x16 to 32 bits, no truncation.
- busy = tag1_v | tag2_v | (fifo_count != 0).

Test Plan:
- Single op: requester 2 issues a=0x1234, b=0x5678 at cycle 0 with rsp_ready=1 → rsp_valid in cycle 3 with rsp_id=2, rsp_result=0x06260060; busy returns to 0 after the pop.
- Round-robin: all four req_valid held high, rsp_ready=1 → grants go 0,1,2,3,0,1,… one per cycle; responses come out in the same ID order with one response per cycle in steady state.
- Backpressure: rsp_ready=0, requester 0 continuously valid → exactly 4 handshakes, then req_ready stays 0. Raising rsp_ready drains 4 responses in order. Issue resumes no earlier than the cycle after the first pop.
- Corner operands: 0xFFFF*0xFFFF → 0xFFFE0001; 0x0000*0xABCD → 0; 0x0001*0xFFFF → 0x0000FFFF; 0x8000*0x0002 → 0x00010000.
- Pointer skip: only requesters 1 and 3 valid, with rr_ptr=2 → grant 3, then 1, then 3; idle requesters 0 and 2 are skipped with no lost cycles.
- Reset mid-operation: 3 ops in flight and 2 buffered, rst_n low for 1 cycle → next cycle rsp_valid=0, busy=0, rr_ptr=0; no stale responses appear afterwards. A fresh op returns only its own result, 3 cycles after accept.
